// File: rtl/l2_request_arbiter_pkg.sv
// ============================================================================
// Module   : l2_request_arbiter_pkg
// Purpose  : Shared types for the L1-to-L2 request arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package l2_request_arbiter_pkg;

    localparam int WORD_BITS = 32;
    localparam int LINE_BITS = 128;

    typedef logic [WORD_BITS-1:0] Word;
    typedef logic [LINE_BITS-1:0] Line;

    typedef enum logic {
        LOAD  = 1'b0,
        STORE = 1'b1
    } MemoryOperation;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ISSUE  = 2'd1,
        ARB_WAIT   = 2'd2,
        ARB_RETURN = 2'd3
    } ArbiterState;

    typedef logic Requester;

    localparam Requester REQUESTER_ICACHE = 1'b0;
    localparam Requester REQUESTER_DCACHE = 1'b1;

endpackage

`default_nettype wire

// File: rtl/l2_request_arbiter_rr_grant_2.sv
// ============================================================================
// Module   : rr_grant_2
// Purpose  : Combinational two-way grant, round-robin or fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_grant_2
    import l2_request_arbiter_pkg::*;
#(
    parameter int FIXED_PRIORITY = 0
) (
    input  logic     i_valid0,
    input  logic     i_valid1,
    input  Requester i_last_grant,
    output Requester o_grant
);

    always_comb begin
        o_grant = REQUESTER_ICACHE;
        if (i_valid0 && i_valid1) begin
            // On a tie, round-robin hands the port to whoever did not win last.
            o_grant = (FIXED_PRIORITY != 0) ? REQUESTER_ICACHE : ~i_last_grant;
        end else if (i_valid1) begin
            o_grant = REQUESTER_DCACHE;
        end
    end

endmodule

`default_nettype wire

// File: rtl/l2_request_arbiter.sv
// ============================================================================
// Module   : l2_request_arbiter
// Purpose  : Shares one L2 port between the I-L1 and D-L1, one transaction in flight.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module l2_request_arbiter
    import l2_request_arbiter_pkg::*;
#(
    parameter int FIXED_PRIORITY = 0
) (
    input  logic           clk_in,
    input  logic           rst_n_in,

    output logic           req0_request_ready_out,
    input  logic           req0_request_valid_in,
    input  Word            req0_request_address_in,
    input  MemoryOperation req0_request_operation_in,
    input  Line            req0_request_data_in,
    input  logic           req0_response_ready_in,
    output logic           req0_response_valid_out,
    output Line            req0_response_data_out,

    output logic           req1_request_ready_out,
    input  logic           req1_request_valid_in,
    input  Word            req1_request_address_in,
    input  MemoryOperation req1_request_operation_in,
    input  Line            req1_request_data_in,
    input  logic           req1_response_ready_in,
    output logic           req1_response_valid_out,
    output Line            req1_response_data_out,

    input  logic           l2_request_ready_in,
    output logic           l2_request_valid_out,
    output Word            l2_request_address_out,
    output MemoryOperation l2_request_operation_out,
    output Line            l2_request_data_out,
    output logic           l2_response_ready_out,
    input  logic           l2_response_valid_in,
    input  Line            l2_response_data_in
);

    ArbiterState    r_state;
    ArbiterState    w_state_next;
    Requester       r_owner;
    Requester       r_last_grant;
    Requester       w_grant;
    Word            r_address;
    MemoryOperation r_operation;
    Line            r_data;
    Line            r_response_data;
    logic           w_idle;
    logic           w_accept;
    logic           w_owner_response_ready;

    rr_grant_2 #(
        .FIXED_PRIORITY (FIXED_PRIORITY)
    ) u_grant (
        .i_valid0     (req0_request_valid_in),
        .i_valid1     (req1_request_valid_in),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant)
    );

    // Ready is gated by reset so nothing is offered while reset is held.
    assign w_idle                 = (r_state == ARB_IDLE) && rst_n_in;
    assign req0_request_ready_out = w_idle && (w_grant == REQUESTER_ICACHE) && req0_request_valid_in;
    assign req1_request_ready_out = w_idle && (w_grant == REQUESTER_DCACHE) && req1_request_valid_in;
    assign w_accept               = req0_request_ready_out || req1_request_ready_out;

    assign w_owner_response_ready = (r_owner == REQUESTER_DCACHE) ? req1_response_ready_in
                                                                  : req0_response_ready_in;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ARB_IDLE: begin
                if (w_accept) begin
                    w_state_next = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                // Stores complete at L2 acceptance; only loads expect a fill.
                if (l2_request_ready_in) begin
                    w_state_next = (r_operation == STORE) ? ARB_IDLE : ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (l2_response_valid_in) begin
                    w_state_next = ARB_RETURN;
                end
            end
            ARB_RETURN: begin
                if (w_owner_response_ready) begin
                    w_state_next = ARB_IDLE;
                end
            end
            default: begin
                w_state_next = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_owner         <= REQUESTER_ICACHE;
            r_last_grant    <= REQUESTER_DCACHE;
            r_address       <= '0;
            r_operation     <= LOAD;
            r_data          <= '0;
            r_response_data <= '0;
        end else begin
            if (w_accept) begin
                r_owner      <= w_grant;
                r_last_grant <= w_grant;
                if (w_grant == REQUESTER_DCACHE) begin
                    r_address   <= req1_request_address_in;
                    r_operation <= req1_request_operation_in;
                    r_data      <= req1_request_data_in;
                end else begin
                    r_address   <= req0_request_address_in;
                    r_operation <= req0_request_operation_in;
                    r_data      <= req0_request_data_in;
                end
            end
            if ((r_state == ARB_WAIT) && l2_response_valid_in) begin
                r_response_data <= l2_response_data_in;
            end
        end
    end

    assign l2_request_valid_out     = (r_state == ARB_ISSUE);
    assign l2_request_address_out   = r_address;
    assign l2_request_operation_out = r_operation;
    assign l2_request_data_out      = r_data;
    assign l2_response_ready_out    = (r_state == ARB_WAIT);

    assign req0_response_valid_out  = (r_state == ARB_RETURN) && (r_owner == REQUESTER_ICACHE);
    assign req1_response_valid_out  = (r_state == ARB_RETURN) && (r_owner == REQUESTER_DCACHE);
    assign req0_response_data_out   = r_response_data;
    assign req1_response_data_out   = r_response_data;

endmodule

`default_nettype wire

// File: tb/tb_l2_request_arbiter.sv
// ============================================================================
// Module   : tb_l2_request_arbiter
// Purpose  : Directed self-checking bench for l2_request_arbiter and rr_grant_2.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_l2_request_arbiter;
    import l2_request_arbiter_pkg::*;

    localparam Line LINE_A = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    localparam Line LINE_B = 128'h11112222_33334444_55556666_77778888;
    localparam Line LINE_C = 128'h99990000_AAAABBBB_CCCCDDDD_EEEEFFFF;
    localparam Line LINE_S = 128'h5A5A5A5A_A5A5A5A5_0F0F0F0F_F0F0F0F0;

    logic           clk_in = 1'b0;
    logic           rst_n_in;
    logic           req0_request_valid_in, req1_request_valid_in;
    Word            req0_request_address_in, req1_request_address_in;
    MemoryOperation req0_request_operation_in, req1_request_operation_in;
    Line            req0_request_data_in, req1_request_data_in;
    logic           req0_response_ready_in, req1_response_ready_in;
    logic           l2_request_ready_in, l2_response_valid_in;
    Line            l2_response_data_in;

    logic           req0_request_ready_out, req1_request_ready_out;
    logic           req0_response_valid_out, req1_response_valid_out;
    Line            req0_response_data_out, req1_response_data_out;
    logic           l2_request_valid_out, l2_response_ready_out;
    Word            l2_request_address_out;
    MemoryOperation l2_request_operation_out;
    Line            l2_request_data_out;

    logic           req0_request_ready_f, req1_request_ready_f;
    logic           req0_response_valid_f, req1_response_valid_f;
    Line            req0_response_data_f, req1_response_data_f;
    logic           l2_request_valid_f, l2_response_ready_f;
    Word            l2_request_address_f;
    MemoryOperation l2_request_operation_f;
    Line            l2_request_data_f;

    logic     tv0, tv1;
    Requester tlast, g_rr, g_fp;

    int total = 0;
    int bad   = 0;

    always #5 clk_in = ~clk_in;

    l2_request_arbiter #(.FIXED_PRIORITY(0)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .req0_request_ready_out(req0_request_ready_out), .req0_request_valid_in(req0_request_valid_in),
        .req0_request_address_in(req0_request_address_in), .req0_request_operation_in(req0_request_operation_in),
        .req0_request_data_in(req0_request_data_in), .req0_response_ready_in(req0_response_ready_in),
        .req0_response_valid_out(req0_response_valid_out), .req0_response_data_out(req0_response_data_out),
        .req1_request_ready_out(req1_request_ready_out), .req1_request_valid_in(req1_request_valid_in),
        .req1_request_address_in(req1_request_address_in), .req1_request_operation_in(req1_request_operation_in),
        .req1_request_data_in(req1_request_data_in), .req1_response_ready_in(req1_response_ready_in),
        .req1_response_valid_out(req1_response_valid_out), .req1_response_data_out(req1_response_data_out),
        .l2_request_ready_in(l2_request_ready_in), .l2_request_valid_out(l2_request_valid_out),
        .l2_request_address_out(l2_request_address_out), .l2_request_operation_out(l2_request_operation_out),
        .l2_request_data_out(l2_request_data_out), .l2_response_ready_out(l2_response_ready_out),
        .l2_response_valid_in(l2_response_valid_in), .l2_response_data_in(l2_response_data_in)
    );

    l2_request_arbiter #(.FIXED_PRIORITY(1)) dut_fp (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .req0_request_ready_out(req0_request_ready_f), .req0_request_valid_in(req0_request_valid_in),
        .req0_request_address_in(req0_request_address_in), .req0_request_operation_in(req0_request_operation_in),
        .req0_request_data_in(req0_request_data_in), .req0_response_ready_in(req0_response_ready_in),
        .req0_response_valid_out(req0_response_valid_f), .req0_response_data_out(req0_response_data_f),
        .req1_request_ready_out(req1_request_ready_f), .req1_request_valid_in(req1_request_valid_in),
        .req1_request_address_in(req1_request_address_in), .req1_request_operation_in(req1_request_operation_in),
        .req1_request_data_in(req1_request_data_in), .req1_response_ready_in(req1_response_ready_in),
        .req1_response_valid_out(req1_response_valid_f), .req1_response_data_out(req1_response_data_f),
        .l2_request_ready_in(l2_request_ready_in), .l2_request_valid_out(l2_request_valid_f),
        .l2_request_address_out(l2_request_address_f), .l2_request_operation_out(l2_request_operation_f),
        .l2_request_data_out(l2_request_data_f), .l2_response_ready_out(l2_response_ready_f),
        .l2_response_valid_in(l2_response_valid_in), .l2_response_data_in(l2_response_data_in)
    );

    rr_grant_2 #(.FIXED_PRIORITY(0)) u_g_rr (.i_valid0(tv0), .i_valid1(tv1), .i_last_grant(tlast), .o_grant(g_rr));
    rr_grant_2 #(.FIXED_PRIORITY(1)) u_g_fp (.i_valid0(tv0), .i_valid1(tv1), .i_last_grant(tlast), .o_grant(g_fp));

    typedef struct packed {
        logic v0;
        logic v1;
        logic last;
        logic fp;
        logic exp_grant;
    } gvec_t;

    gvec_t gv [10];

    task automatic chk1(input string nm, input logic act, input logic exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s actual=%0b required=%0b", nm, act, exp_v);
        end
    endtask

    task automatic chkw(input string nm, input logic [127:0] act, input logic [127:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic reset_pulse();
        rst_n_in = 1'b0;
        step();
        rst_n_in = 1'b1;
    endtask

    int       n_rr, n_fp;
    Requester got_rr [6];
    Requester got_fp [6];

    initial begin
        rst_n_in = 1'b0;
        req0_request_valid_in = 1'b0; req1_request_valid_in = 1'b0;
        req0_request_address_in = '0; req1_request_address_in = '0;
        req0_request_operation_in = LOAD; req1_request_operation_in = LOAD;
        req0_request_data_in = '0; req1_request_data_in = '0;
        req0_response_ready_in = 1'b0; req1_response_ready_in = 1'b0;
        l2_request_ready_in = 1'b0; l2_response_valid_in = 1'b0; l2_response_data_in = '0;
        tv0 = 1'b0; tv1 = 1'b0; tlast = 1'b0;

        // Standalone grant table: {valid0, valid1, last_grant, fixed_priority, expected}
        gv[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        gv[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        gv[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        gv[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        gv[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        gv[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        gv[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        gv[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        gv[8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        gv[9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 10; i++) begin
            tv0 = gv[i].v0; tv1 = gv[i].v1; tlast = gv[i].last;
            #1;
            chk1($sformatf("grant_vec%0d", i), gv[i].fp ? g_fp : g_rr, gv[i].exp_grant);
        end

        // Reset state, with both requesters valid to show ready is held low
        step(); step();
        req0_request_valid_in = 1'b1; req1_request_valid_in = 1'b1;
        #1;
        chk1("rst_ready0", req0_request_ready_out, 1'b0);
        chk1("rst_ready1", req1_request_ready_out, 1'b0);
        chk1("rst_l2_valid", l2_request_valid_out, 1'b0);
        chkw("rst_l2_addr", 128'(l2_request_address_out), 128'h0);
        chk1("rst_l2_op", l2_request_operation_out, LOAD);
        chkw("rst_l2_data", l2_request_data_out, 128'h0);
        chk1("rst_l2_rsp_ready", l2_response_ready_out, 1'b0);
        chk1("rst_rsp0_valid", req0_response_valid_out, 1'b0);
        chk1("rst_rsp1_valid", req1_response_valid_out, 1'b0);
        chkw("rst_rsp0_data", req0_response_data_out, 128'h0);
        req0_request_valid_in = 1'b0; req1_request_valid_in = 1'b0;
        rst_n_in = 1'b1;
        step();

        // Basic LOAD from requester 0, minimum latency
        req0_request_valid_in = 1'b1; req0_request_address_in = 32'h0000_1000; req0_request_operation_in = LOAD;
        l2_request_ready_in = 1'b1; l2_response_valid_in = 1'b1; l2_response_data_in = LINE_A;
        req0_response_ready_in = 1'b1; req1_response_ready_in = 1'b1;
        #1;
        chk1("t1_ready0", req0_request_ready_out, 1'b1);
        chk1("t1_ready1", req1_request_ready_out, 1'b0);
        step();
        req0_request_valid_in = 1'b0;
        #1;
        chk1("t1_l2_valid", l2_request_valid_out, 1'b1);
        chkw("t1_l2_addr", 128'(l2_request_address_out), 128'h1000);
        chk1("t1_l2_op", l2_request_operation_out, LOAD);
        step();
        chk1("t1_l2_rsp_ready", l2_response_ready_out, 1'b1);
        chk1("t1_rsp0_early", req0_response_valid_out, 1'b0);
        step();
        chk1("t1_rsp0_valid", req0_response_valid_out, 1'b1);
        chkw("t1_rsp0_data", req0_response_data_out, LINE_A);
        chk1("t1_rsp1_valid", req1_response_valid_out, 1'b0);
        step();
        chk1("t1_rsp0_done", req0_response_valid_out, 1'b0);

        // Continuous contention on both instances
        reset_pulse();
        req0_request_valid_in = 1'b1; req1_request_valid_in = 1'b1;
        req0_request_address_in = 32'h0000_0100; req1_request_address_in = 32'h0000_0200;
        req0_request_operation_in = LOAD; req1_request_operation_in = LOAD;
        n_rr = 0; n_fp = 0;
        for (int c = 0; c < 30; c++) begin
            #1;
            if (n_rr < 6 && (req0_request_ready_out || req1_request_ready_out)) begin
                got_rr[n_rr] = req1_request_ready_out;
                n_rr++;
            end
            if (n_fp < 6 && (req0_request_ready_f || req1_request_ready_f)) begin
                got_fp[n_fp] = req1_request_ready_f;
                n_fp++;
            end
            step();
        end
        chkw("t2_rr_count", 128'(n_rr), 128'd6);
        chkw("t2_fp_count", 128'(n_fp), 128'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < n_rr) chk1($sformatf("t2_rr_grant%0d", i), got_rr[i], Requester'(i % 2));
            if (i < n_fp) chk1($sformatf("t2_fp_grant%0d", i), got_fp[i], REQUESTER_ICACHE);
        end
        req0_request_valid_in = 1'b0; req1_request_valid_in = 1'b0;

        // Requester 1 STORE with L2 stalling for 4 cycles
        reset_pulse();
        l2_request_ready_in = 1'b0; l2_response_valid_in = 1'b0;
        req1_request_valid_in = 1'b1; req1_request_address_in = 32'h0000_2040;
        req1_request_operation_in = STORE; req1_request_data_in = LINE_S;
        #1;
        chk1("t3_ready1", req1_request_ready_out, 1'b1);
        step();
        req1_request_valid_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk1($sformatf("t3_l2_valid%0d", i), l2_request_valid_out, 1'b1);
            chkw($sformatf("t3_l2_addr%0d", i), 128'(l2_request_address_out), 128'h2040);
            chk1($sformatf("t3_l2_op%0d", i), l2_request_operation_out, STORE);
            chkw($sformatf("t3_l2_data%0d", i), l2_request_data_out, LINE_S);
            step();
        end
        l2_request_ready_in = 1'b1;
        #1;
        chk1("t3_l2_valid_final", l2_request_valid_out, 1'b1);
        step();
        l2_request_ready_in = 1'b0; l2_response_valid_in = 1'b1;
        req0_request_valid_in = 1'b1; req0_request_address_in = 32'h0000_5000; req0_request_operation_in = LOAD;
        #1;
        chk1("t3_idle_ready0", req0_request_ready_out, 1'b1);
        chk1("t3_l2_valid_after", l2_request_valid_out, 1'b0);
        chk1("t3_l2_rsp_ready", l2_response_ready_out, 1'b0);
        req0_request_valid_in = 1'b0;
        step();
        chk1("t3_rsp0_none", req0_response_valid_out, 1'b0);
        chk1("t3_rsp1_none", req1_response_valid_out, 1'b0);
        l2_response_valid_in = 1'b0;

        // LOAD held in RETURN while requester 0 stalls; requester 1 must wait
        req0_request_valid_in = 1'b1; req0_request_address_in = 32'h0000_3000; req0_request_operation_in = LOAD;
        req1_request_valid_in = 1'b1; req1_request_address_in = 32'h0000_3100; req1_request_operation_in = LOAD;
        l2_request_ready_in = 1'b1; l2_response_valid_in = 1'b1; l2_response_data_in = LINE_B;
        req0_response_ready_in = 1'b0;
        #1;
        chk1("t4_ready0", req0_request_ready_out, 1'b1);
        step();
        req0_request_valid_in = 1'b0;
        #1;
        chk1("t4_issue_ready1", req1_request_ready_out, 1'b0);
        step();
        chk1("t4_wait_ready1", req1_request_ready_out, 1'b0);
        step();
        l2_response_data_in = LINE_C;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk1($sformatf("t4_rsp0_valid%0d", i), req0_response_valid_out, 1'b1);
            chkw($sformatf("t4_rsp0_data%0d", i), req0_response_data_out, LINE_B);
            chk1($sformatf("t4_ready1_%0d", i), req1_request_ready_out, 1'b0);
            step();
        end
        req0_response_ready_in = 1'b1;
        step();
        chk1("t4_rsp0_done", req0_response_valid_out, 1'b0);
        chk1("t4_ready1_after", req1_request_ready_out, 1'b1);
        req1_request_valid_in = 1'b0;

        // L2 response pulses in IDLE and ISSUE are not consumed
        l2_response_valid_in = 1'b1; l2_request_ready_in = 1'b0;
        #1;
        chk1("t5_idle_rsp_ready", l2_response_ready_out, 1'b0);
        step();
        chk1("t5_idle_rsp0", req0_response_valid_out, 1'b0);
        chk1("t5_idle_rsp1", req1_response_valid_out, 1'b0);
        req0_request_valid_in = 1'b1; req0_request_address_in = 32'h0000_4000; req0_request_operation_in = LOAD;
        #1;
        step();
        req0_request_valid_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk1($sformatf("t5_issue_rsp_ready%0d", i), l2_response_ready_out, 1'b0);
            chk1($sformatf("t5_issue_l2_valid%0d", i), l2_request_valid_out, 1'b1);
            chk1($sformatf("t5_issue_rsp0_%0d", i), req0_response_valid_out, 1'b0);
            step();
        end
        l2_response_valid_in = 1'b0; l2_request_ready_in = 1'b1;
        step();
        chk1("t5_wait_rsp_ready", l2_response_ready_out, 1'b1);

        // Asynchronous reset while waiting on L2
        req0_request_valid_in = 1'b1; req1_request_valid_in = 1'b1;
        req0_request_address_in = 32'h0000_6000;
        #2;
        rst_n_in = 1'b0;
        #1;
        chk1("t6_rsp_ready", l2_response_ready_out, 1'b0);
        chk1("t6_l2_valid", l2_request_valid_out, 1'b0);
        chk1("t6_ready0", req0_request_ready_out, 1'b0);
        chk1("t6_ready1", req1_request_ready_out, 1'b0);
        chk1("t6_rsp0", req0_response_valid_out, 1'b0);
        chk1("t6_rsp1", req1_response_valid_out, 1'b0);
        #2;
        rst_n_in = 1'b1;
        #1;
        chk1("t6_tie_ready0", req0_request_ready_out, 1'b1);
        chk1("t6_tie_ready1", req1_request_ready_out, 1'b0);
        chk1("t6_fp_tie_ready0", req0_request_ready_f, 1'b1);
        step();
        req0_request_valid_in = 1'b0; req1_request_valid_in = 1'b0;
        #1;
        chkw("t6_l2_addr", 128'(l2_request_address_out), 128'h6000);
        step(); step(); step();
        chk1("t6_no_rsp0", req0_response_valid_out, 1'b0);
        chk1("t6_no_rsp1", req1_response_valid_out, 1'b0);
        chk1("t6_still_wait", l2_response_ready_out, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
